// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding for the alu_pipe two-stage ALU.
package alu_pipe_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      ADD      = 3'b000,
      SUB      = 3'b001,
      AND      = 3'b010,
      OR       = 3'b011,
      XOR      = 3'b100,
      ADD3     = 3'b101,
      ACC_LOAD = 3'b110,
      ACC_ADD  = 3'b111
   } op_e;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath for alu_pipe: result plus accumulator next-value.
// ALU_PIPE_SAT_EN selects clamping arithmetic instead of wrap-around.
module alu_pipe_core
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   input  op_e              op_i,
   input  logic [WIDTH-1:0] acc_i,
   output logic [WIDTH:0]   ret_o,
   output logic             acc_we_o,
   output logic [WIDTH-1:0] acc_d_o
);

`ifdef ALU_PIPE_SAT_EN
   // One spare bit so a three-way sum never hides an overflow.
   localparam int S3_W = WIDTH + 2;
`else
   localparam int S3_W = WIDTH + 1;
`endif

   logic [WIDTH:0]  sum_ab;
   logic [WIDTH:0]  diff_ab;
   logic [WIDTH:0]  sum_acc;
   logic [S3_W-1:0] sum3;
   logic [WIDTH:0]  acc_res;

   assign sum_ab  = {1'b0, a_i} + {1'b0, b_i};
   assign diff_ab = {1'b0, a_i} - {1'b0, b_i};
   assign sum_acc = {1'b0, acc_i} + {1'b0, a_i};
   assign sum3    = S3_W'(a_i) + S3_W'(b_i) + S3_W'(c_i);

`ifdef ALU_PIPE_SAT_EN
   function automatic logic [WIDTH:0] sat_hi(input logic ovf, input logic [WIDTH-1:0] low);
      return ovf ? {1'b1, {WIDTH{1'b1}}} : {1'b0, low};
   endfunction

   function automatic logic [WIDTH:0] sat_lo(input logic [WIDTH:0] diff);
      return diff[WIDTH] ? {1'b1, {WIDTH{1'b0}}} : diff;
   endfunction

   assign acc_res = sat_hi(sum_acc[WIDTH], sum_acc[WIDTH-1:0]);
`else
   assign acc_res = sum_acc;
`endif

   always_comb begin
      ret_o    = '0;
      acc_we_o = 1'b0;
      acc_d_o  = acc_i;
      case (op_i)
`ifdef ALU_PIPE_SAT_EN
         ADD:  ret_o = sat_hi(sum_ab[WIDTH], sum_ab[WIDTH-1:0]);
         SUB:  ret_o = sat_lo(diff_ab);
         ADD3: ret_o = sat_hi(|sum3[S3_W-1:WIDTH], sum3[WIDTH-1:0]);
`else
         ADD:  ret_o = sum_ab;
         SUB:  ret_o = diff_ab;
         ADD3: ret_o = sum3;
`endif
         AND:  ret_o = {1'b0, a_i & b_i};
         OR:   ret_o = {1'b0, a_i | b_i};
         XOR:  ret_o = {1'b0, a_i ^ b_i};
         ACC_LOAD: begin
            ret_o    = {1'b0, a_i};
            acc_we_o = 1'b1;
            acc_d_o  = a_i;
         end
         ACC_ADD: begin
            ret_o    = acc_res;
            acc_we_o = 1'b1;
            acc_d_o  = acc_res[WIDTH-1:0];
         end
         default: ret_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with an internal accumulator.
// Define ALU_PIPE_SAT_EN to build the saturating arithmetic variant.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] ACC_RST = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [OP_W-1:0]  sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   ret,
   output logic [WIDTH-1:0] acc
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [WIDTH-1:0] s1_c_q, s1_c_d;
   op_e              s1_op_q, s1_op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH:0]   ret_q, ret_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             s1_load;
   logic             s2_load;
   logic [WIDTH:0]   core_ret;
   logic             core_acc_we;
   logic [WIDTH-1:0] core_acc;

   // A stage may take new data when it is empty or its content moves on.
   assign s2_load  = !out_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   alu_pipe_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a_i      (s1_a_q),
      .b_i      (s1_b_q),
      .c_i      (s1_c_q),
      .op_i     (s1_op_q),
      .acc_i    (acc_q),
      .ret_o    (core_ret),
      .acc_we_o (core_acc_we),
      .acc_d_o  (core_acc)
   );

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_c_d      = s1_c_q;
      s1_op_d     = s1_op_q;
      out_valid_d = out_valid_q;
      ret_d       = ret_q;
      acc_d       = acc_q;

      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d  = a;
            s1_b_d  = b;
            s1_c_d  = c;
            s1_op_d = op_e'(sel);
         end
      end

      // Accumulator commits with the S2 load, so the next ACC op in S1 sees it.
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            ret_d = core_ret;
            if (core_acc_we) begin
               acc_d = core_acc;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_c_q      <= '0;
         s1_op_q     <= ADD;
         out_valid_q <= 1'b0;
         ret_q       <= '0;
         acc_q       <= ACC_RST;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_c_q      <= s1_c_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         ret_q       <= ret_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign ret       = ret_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed steps plus random traffic vs a reference model.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a, b, c;
   logic [2:0] sel;
   logic       out_ready;
   logic       in_ready;
   logic       out_valid;
   logic [4:0] ret;
   logic [3:0] acc;

   logic       iv8, ordy8;
   logic [7:0] a8, b8, c8;
   logic [2:0] sel8;
   logic       in_ready8, ov8;
   logic [8:0] ret8;
   logic [7:0] acc8;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_m = 0;
   int n_full = 0;
   bit chk_lat = 1'b0;
   bit prev_stall = 1'b0;
   logic [4:0] prev_ret;
   int exp_q[$];
   int tacc_q[$];
   int got_q[$];

   alu_pipe #(.WIDTH(4), .ACC_RST(4'd0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .sel(sel), .out_valid(out_valid),
      .out_ready(out_ready), .ret(ret), .acc(acc)
   );

   alu_pipe #(.WIDTH(8), .ACC_RST(8'd0)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8),
      .a(a8), .b(b8), .c(c8), .sel(sel8), .out_valid(ov8),
      .out_ready(ordy8), .ret(ret8), .acc(acc8)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int clampv(input int s, input int mx);
`ifdef ALU_PIPE_SAT_EN
      return (s > mx) ? ((mx + 1) | mx) : s;
`else
      return s;
`endif
   endfunction

   // Opcode semantics in plain integer arithmetic.
   task automatic ref_op(input int w, input int av, input int bv, input int cv, input int op,
                         input int acc_in, output int r, output int acc_out);
      int top, mx;
      top = 1 << w;
      mx  = top - 1;
      acc_out = acc_in;
      case (op)
         0: r = clampv(av + bv, mx);
         1: begin
            if (av >= bv) r = av - bv;
`ifdef ALU_PIPE_SAT_EN
            else r = top;
`else
            else r = av - bv + 2 * top;
`endif
         end
         2: r = av & bv;
         3: r = av | bv;
         4: r = av ^ bv;
         5: r = clampv(av + bv + cv, mx) % (2 * top);
         6: begin r = av; acc_out = av; end
         default: begin r = clampv(acc_in + av, mx); acc_out = r & mx; end
      endcase
   endtask

   task automatic step(input bit v, input int av, input int bv, input int cv, input int sv,
                       input bit ordy, output bit took);
      int r, na, t;
      in_valid  = v;
      a         = av[3:0];
      b         = bv[3:0];
      c         = cv[3:0];
      sel       = sv[2:0];
      out_ready = ordy;
      @(negedge clk);
      cyc++;
      chk("in_ready", in_ready, (exp_q.size() < 2) || ordy);
      if (!in_ready) n_full++;
      if (prev_stall) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_ret", ret, prev_ret);
      end
      if (exp_q.size() == 0) chk("no_stale", out_valid, 1'b0);
      prev_stall = out_valid && !ordy;
      prev_ret   = ret;
      if (out_valid && ordy && exp_q.size() != 0) begin
         r = exp_q.pop_front();
         t = tacc_q.pop_front();
         chk("ret", ret, r);
         got_q.push_back(int'(ret));
         if (chk_lat) chk("latency", cyc - t, 2);
      end
      took = v && in_ready;
      if (took) begin
         ref_op(4, av, bv, cv, sv, acc_m, r, na);
         acc_m = na;
         exp_q.push_back(r);
         tacc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int av, input int bv, input int cv, input int sv, input bit ordy);
      bit tk;
      int n;
      n = 0;
      do begin
         step(1'b1, av, bv, cv, sv, ordy, tk);
         n++;
      end while (!tk && n < 20);
      chk("accept", tk, 1'b1);
   endtask

   task automatic drain();
      bit tk;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step(1'b0, 0, 0, 0, 0, 1'b1, tk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      step(1'b0, 0, 0, 0, 0, 1'b1, tk);
      step(1'b0, 0, 0, 0, 0, 1'b1, tk);
   endtask

   initial begin
      int base, idx, stall, n;
      int ba[5], bb[5];
      int spec_basic[6];
      int spec_acc[3];
      int spec_sat[2];
      int acc_end;
      logic [8:0] w8_add, w8_sub;
      int ra, rb, rc, rs;
      bit rv, rr, tk, ordy;

`ifdef ALU_PIPE_SAT_EN
      spec_basic = '{12, 16, 5, 7, 2, 13};
      spec_acc   = '{5, 10, 31};
      spec_sat   = '{31, 16};
      acc_end    = 15;
      w8_add     = 9'h1FF;
      w8_sub     = 9'h100;
`else
      spec_basic = '{12, 30, 5, 7, 2, 13};
      spec_acc   = '{5, 10, 19};
      spec_sat   = '{30, 30};
      acc_end    = 3;
      w8_add     = 9'h12C;
      w8_sub     = 9'h1FF;
`endif

      in_valid = 0; a = 0; b = 0; c = 0; sel = 0; out_ready = 1;
      iv8 = 0; a8 = 0; b8 = 0; c8 = 0; sel8 = 0; ordy8 = 1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_ret", ret, 5'd0);
      chk("rst_acc", acc, 4'd0);
      chk("rst_ov8", ov8, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);

      // Basic opcodes, one per cycle.
      chk_lat = 1'b1;
      base = got_q.size();
      for (int s = 0; s < 6; s++) issue(5, 7, 1, s, 1'b1);
      drain();
      for (int i = 0; i < 6; i++) chk("basic_spec", got_q[base + i], spec_basic[i]);

      // Back-to-back accumulator ops.
      base = got_q.size();
      issue(5, 0, 0, 6, 1'b1);
      issue(5, 0, 0, 7, 1'b1);
      issue(9, 0, 0, 7, 1'b1);
      drain();
      for (int i = 0; i < 3; i++) chk("acc_spec", got_q[base + i], spec_acc[i]);
      chk("acc_end", acc, acc_end);

      // Overflow / underflow corners.
      base = got_q.size();
      issue(15, 15, 0, 0, 1'b1);
      issue(5, 7, 0, 1, 1'b1);
      drain();
      for (int i = 0; i < 2; i++) chk("ovf_spec", got_q[base + i], spec_sat[i]);
      chk_lat = 1'b0;

      // Back-pressure: out_ready low for 3 cycles after the first result.
      for (int i = 0; i < 5; i++) begin
         ba[i] = $urandom_range(0, 15);
         bb[i] = $urandom_range(0, 15);
      end
      base = got_q.size();
      idx = 0; stall = 0; n = 0; n_full = 0;
      while ((idx < 4 || exp_q.size() != 0) && n < 40) begin
         ordy = 1'b1;
         if (got_q.size() > base && stall < 3) begin
            ordy = 1'b0;
            stall++;
         end
         step(idx < 4, ba[idx], bb[idx], 0, 0, ordy, tk);
         if (tk) idx++;
         n++;
      end
      chk("bp_full_seen", n_full > 0, 1'b1);
      chk("bp_count", got_q.size() - base, 4);
      drain();

      // Random traffic with random back-pressure, honouring the hold rule.
      tk = 1'b1; rv = 1'b0; ra = 0; rb = 0; rc = 0; rs = 0;
      for (int i = 0; i < 300; i++) begin
         if (!(rv && !tk)) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            rc = $urandom_range(0, 15);
            rs = $urandom_range(0, 7);
         end
         rr = ($urandom_range(0, 3) != 0);
         step(rv, ra, rb, rc, rs, rr, tk);
      end
      drain();
      chk("acc_rand", acc, acc_m[3:0]);

      // Asynchronous reset with two ops in flight.
      issue(9, 0, 0, 6, 1'b1);
      issue(1, 2, 0, 0, 1'b1);
      chk("acc_pre_rst", acc, 4'd9);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_acc", acc, 4'd0);
      exp_q.delete();
      tacc_q.delete();
      acc_m = 0;
      prev_stall = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 0, 0, 1'b1, tk);
      issue(3, 0, 0, 7, 1'b1);
      drain();
      chk("postrst_acc", acc, 4'd3);

      // WIDTH=8 instance.
      a8 = 8'd200; b8 = 8'd100; c8 = 8'd0; sel8 = 3'b000; iv8 = 1'b1;
      @(posedge clk);
      #1;
      chk("w8_in_ready", in_ready8, 1'b1);
      a8 = 8'd3; b8 = 8'd4; sel8 = 3'b001;
      @(posedge clk);
      #1;
      iv8 = 1'b0;
      chk("w8_valid", ov8, 1'b1);
      chk("w8_add", ret8, w8_add);
      @(posedge clk);
      #1;
      chk("w8_sub", ret8, w8_sub);
      @(posedge clk);
      #1;
      chk("w8_idle", ov8, 1'b0);
      chk("w8_acc", acc8, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
